sprite_rom_arbiter: RTL and testbench
=====================================

Name: sprite_rom_arbiter

Overview:
- Shares the single 32x32 monochrome sprite ROM between NREQ requesters (tank 1, tank 2, bullet and brick renderers) using round-robin arbitration.
- Each requester asks for one sprite bit: type/direction plus row/column. The block grants one request per cycle and forms the ROM address. It returns the bit two cycles later, tagged with the requester id.
- Sits between the object renderers and the sprite graphics ROM, in the pixel clock domain.

Parameters:
- NREQ, 4, number of requesters; 2..8.
- IDW, $clog2(NREQ), width of the requester id.

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- req  in  NREQ  per-requester request level.
- req_dir  in  NREQ x 2  tank direction 0..3.
- req_bul  in  NREQ  select the bullet sprite.
- req_brk  in  NREQ  select the brick sprite.
- req_row  in  NREQ x 5  sprite row 0..31.
- req_col  in  NREQ x 5  sprite column 0..31.
- gnt  out  NREQ  one-hot grant, combinational, same cycle as acceptance.
- rom_addr  out  8  registered address to the graphics ROM.
- rom_data  in  32  ROM row word, valid the cycle after rom_addr.
- rsp_valid  out  1  response strobe.
- rsp_id  out  IDW  id of the requester being answered.
- rsp_pixel  out  1  sprite bit.
- busy  out  1  high while any response is in flight.

Behaviour:
- Handshake:
  - A requester holds req high with stable fields until it sees gnt.
  - A request is accepted in the cycle its gnt bit is high.
  - Dropping req before the grant withdraws it without side effects.
- Arbitration:
  - Round-robin pointer ptr, reset to 0.
  - Grant the first asserted req at index ptr, ptr+1, ... mod NREQ.
  - On a grant to index k, ptr <= (k+1) mod NREQ. With no requests, ptr holds.
  - At most one gnt bit is high per cycle; gnt is 0 when Reset is high.
- Address formation (registered into stage 1, on the accepted request):
  - bul=1 -> 128 + row.
  - else brk=1 -> 160 + row.
  - else 32*dir + row.
  - bul has priority over brk, which has priority over dir. Addresses 192..255 are never generated.
- Pipeline:
  - S1 registers: v1, id1, col1, rom_addr.
  - S2 registers: rsp_valid <= v1, rsp_id <= id1, rsp_pixel <= rom_data[31 - col1].
  - Column 0 maps to the MSB.
  - Latency is 2 cycles from acceptance to rsp_valid. Throughput is 1 response per cycle, with no backpressure.
- busy = v1 | rsp_valid.
- Reset values: gnt=0, rom_addr=0, rsp_valid=0, rsp_id=0, rsp_pixel=0, busy=0, ptr=0, v1=0.
- Reset mid-operation: all in-flight responses are discarded; no rsp_valid appears after the Reset cycle.
- Back-to-back grants to the same requester are legal when it is the only one requesting; ptr still advances past it.
- Simultaneous requests from all NREQ requesters: each is served once in NREQ consecutive cycles, in pointer order.
- Row/column arithmetic is 8-bit unsigned; row and column are used modulo 32, so no wrap-around logic is needed.

Decomposition:
- Package sprite_pkg:
  - SPR_W=32.
  - Base constants SPR_TANK_BASE=0, SPR_BUL_BASE=128, SPR_BRK_BASE=160.
  - dir_t enum UP=0, RIGHT=1, DOWN=2, LEFT=3.
  - Function spr_addr(dir, bul, brk, row) returning 8 bits.
- Sub-module rr_arbiter (NREQ parameter): inputs req, advance; outputs one-hot gnt, gnt_idx; owns ptr.

Test Plan:
- Single request: after Reset, req[2]=1, dir=1, row=5, col=3 -> gnt=0100 that cycle; rom_addr=37 next cycle; rsp_valid=1, rsp_id=2, rsp_pixel=rom_data[28] the following cycle.
- Sprite select priority: requester 0 with bul=1, brk=1, row=7 -> rom_addr=135. Same request with brk=1, bul=0 -> 167.
- Fairness: req=1111 held for 8 cycles from ptr=0 -> gnt sequence 0001, 0010, 0100, 1000, repeated twice; rsp_id sequence 0,1,2,3,0,1,2,3 starting 2 cycles later.
- Skip and withdraw: ptr=1, req=1001 -> gnt=1000 then 0001. Then req[1] raised and dropped in the same cycle that requester 0 is granted -> no response with id 1.
- Reset mid-flight: grant on cycle N, Reset high on cycle N+1 -> rsp_valid stays 0 through N+3; ptr=0 afterwards.
- Idle: req=0000 for 10 cycles -> gnt=0, rsp_valid=0, busy=0, ptr unchanged.

Source files
------------

// File: rtl/sprite_pkg.sv
// Sprite ROM map shared by the arbiter and its clients: base addresses of the
// three sprite families, the tank direction encoding and the address helper.
package sprite_pkg;

  localparam int SPR_W = 32;

  localparam logic [7:0] SPR_TANK_BASE = 8'd0;
  localparam logic [7:0] SPR_BUL_BASE  = 8'd128;
  localparam logic [7:0] SPR_BRK_BASE  = 8'd160;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    RIGHT = 2'd1,
    DOWN  = 2'd2,
    LEFT  = 2'd3
  } dir_t;

  // Bullet beats brick beats tank; tanks occupy four 32-row blocks, one per
  // direction, so the upper quarter of the ROM (192..255) is never addressed.
  function automatic logic [7:0] spr_addr(dir_t dir, logic bul, logic brk,
                                          logic [4:0] row);
    logic [7:0] w_row;
    w_row = {3'b000, row};
    if (bul)      return SPR_BUL_BASE + w_row;
    else if (brk) return SPR_BRK_BASE + w_row;
    else          return SPR_TANK_BASE + {1'b0, dir, row};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first asserted request at or after the
// pointer and moves the pointer just past the winner when advance is high.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_idx
);

  logic [IDW-1:0] r_ptr;
  logic [IDW:0]   w_cand;
  logic [IDW-1:0] w_idx;
  logic           w_found;

  // Scan ptr, ptr+1, ... (mod NREQ) for the first live request.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    w_found = 1'b0;
    w_idx   = '0;
    w_cand  = '0;
    gnt     = '0;
    for (int off = 0; off < NREQ; off++) begin
      w_cand = {1'b0, r_ptr} + (IDW+1)'(off);
      if (w_cand >= (IDW+1)'(NREQ)) w_cand = w_cand - (IDW+1)'(NREQ);
      if (!w_found && req[w_cand[IDW-1:0]]) begin
        w_found = 1'b1;
        w_idx   = w_cand[IDW-1:0];
      end
    end
    if (w_found && advance) gnt[w_idx] = 1'b1;
  end

  assign gnt_idx = w_idx;

  // Pointer moves past the granted index; holds when nothing is granted.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so all flops sample together.
    if (reset) begin
      r_ptr <= '0;
    end else if (w_found && advance) begin
      r_ptr <= (w_idx == IDW'(NREQ-1)) ? '0 : w_idx + 1'b1;
    end
  end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Shares the 32x32 monochrome sprite ROM between NREQ renderers. One request
// is accepted per cycle; its sprite bit comes back two cycles later tagged
// with the requester id.
module sprite_rom_arbiter
  import sprite_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [NREQ-1:0]   req,
  input  logic [2*NREQ-1:0] req_dir,
  input  logic [NREQ-1:0]   req_bul,
  input  logic [NREQ-1:0]   req_brk,
  input  logic [5*NREQ-1:0] req_row,
  input  logic [5*NREQ-1:0] req_col,
  output logic [NREQ-1:0]   gnt,
  output logic [7:0]        rom_addr,
  input  logic [31:0]       rom_data,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic              rsp_pixel,
  output logic              busy
);

  logic [NREQ-1:0] w_req;
  logic [NREQ-1:0] w_gnt;
  logic [IDW-1:0]  w_gnt_idx;
  logic            w_accept;

  logic [1:0]      w_dir;
  logic            w_bul;
  logic            w_brk;
  logic [4:0]      w_row;
  logic [4:0]      w_col;

  logic            r_v1;
  logic [IDW-1:0]  r_id1;
  logic [4:0]      r_col1;
  logic [7:0]      r_rom_addr;
  logic            r_rsp_valid;
  logic [IDW-1:0]  r_rsp_id;
  logic            r_rsp_pixel;

  // Requests are masked during Reset so nothing is granted or accepted.
  assign w_req = Reset ? '0 : req;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .clk     (Clk),
    .reset   (Reset),
    .req     (w_req),
    .advance (~Reset),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx)
  );

  assign gnt      = w_gnt;
  assign w_accept = |w_gnt;

  // Pick the granted requester's sprite fields.
  always_comb begin
    w_dir = '0;
    w_bul = 1'b0;
    w_brk = 1'b0;
    w_row = '0;
    w_col = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt_idx == IDW'(i)) begin
        w_dir = req_dir[2*i +: 2];
        w_bul = req_bul[i];
        w_brk = req_brk[i];
        w_row = req_row[5*i +: 5];
        w_col = req_col[5*i +: 5];
      end
    end
  end

  // Stage 1: capture the accepted request and drive the ROM address.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_v1       <= 1'b0;
      r_id1      <= '0;
      r_col1     <= '0;
      r_rom_addr <= '0;
    end else begin
      r_v1 <= w_accept;
      if (w_accept) begin
        r_id1      <= w_gnt_idx;
        r_col1     <= w_col;
        r_rom_addr <= spr_addr(dir_t'(w_dir), w_bul, w_brk, w_row);
      end
    end
  end

  // Stage 2: pick the column bit out of the ROM word; column 0 is the MSB.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_pixel <= 1'b0;
    end else begin
      r_rsp_valid <= r_v1;
      r_rsp_id    <= r_id1;
      r_rsp_pixel <= rom_data[5'(SPR_W-1) - r_col1];
    end
  end

  assign rom_addr  = r_rom_addr;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_pixel = r_rsp_pixel;
  assign busy      = r_v1 | r_rsp_valid;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Bench for sprite_rom_arbiter: directed scenarios with literal expectations
// plus a transaction-level model (scheduled responses) checked every cycle.
module tb_sprite_rom_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk;
  logic              Reset;
  logic [NREQ-1:0]   req;
  logic [2*NREQ-1:0] req_dir;
  logic [NREQ-1:0]   req_bul;
  logic [NREQ-1:0]   req_brk;
  logic [5*NREQ-1:0] req_row;
  logic [5*NREQ-1:0] req_col;
  logic [NREQ-1:0]   gnt;
  logic [7:0]        rom_addr;
  logic [31:0]       rom_data;
  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic              rsp_pixel;
  logic              busy;

  logic [31:0] rom_mem [256];

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  sprite_rom_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .Clk       (clk),
    .Reset     (Reset),
    .req       (req),
    .req_dir   (req_dir),
    .req_bul   (req_bul),
    .req_brk   (req_brk),
    .req_row   (req_row),
    .req_col   (req_col),
    .gnt       (gnt),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_pixel (rsp_pixel),
    .busy      (busy)
  );

  assign rom_data = rom_mem[rom_addr];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- model
  typedef struct {
    int   due;
    int   id;
    logic pix;
  } rsp_t;

  rsp_t q[$];
  int   m_ptr  = 0;
  int   m_addr = 0;

  function automatic int model_addr(int dir, bit bul, bit brk, int row);
    if (bul)      return 128 + row;
    else if (brk) return 160 + row;
    else          return 32 * dir + row;
  endfunction

  always @(negedge clk) begin : model_cmp
    int   k;
    int   j;
    int   a;
    int   col;
    logic [NREQ-1:0] eg;
    logic ev;
    logic eb;
    if (cyc >= 1) begin
      k  = -1;
      eg = '0;
      if (!Reset) begin
        for (int off = 0; off < NREQ; off++) begin
          j = (m_ptr + off) % NREQ;
          if (k < 0 && req[j]) k = j;
        end
      end
      if (k >= 0) eg[k] = 1'b1;
      check("model_gnt", 32'(gnt), 32'(eg));

      while (q.size() > 0 && q[0].due < cyc) void'(q.pop_front());
      ev = (q.size() > 0) && (q[0].due == cyc);
      check("model_rsp_valid", 32'(rsp_valid), 32'(ev));
      if (ev) begin
        check("model_rsp_id", 32'(rsp_id), 32'(q[0].id));
        check("model_rsp_pixel", 32'(rsp_pixel), 32'(q[0].pix));
      end
      eb = 1'b0;
      foreach (q[i]) if (q[i].due == cyc || q[i].due == cyc + 1) eb = 1'b1;
      check("model_busy", 32'(busy), 32'(eb));
      check("model_rom_addr", 32'(rom_addr), 32'(m_addr));

      if (ev) void'(q.pop_front());
      if (Reset) begin
        q.delete();
        m_ptr  = 0;
        m_addr = 0;
      end else if (k >= 0) begin
        a   = model_addr(int'(req_dir[2*k +: 2]), req_bul[k], req_brk[k],
                         int'(req_row[5*k +: 5]));
        col = int'(req_col[5*k +: 5]);
        m_addr = a;
        q.push_back('{due: cyc + 2, id: k, pix: rom_mem[a][31 - col]});
        m_ptr = (k + 1) % NREQ;
      end
    end
  end

  // ------------------------------------------------------------ stimulus
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic clear_req();
    req = '0; req_dir = '0; req_bul = '0; req_brk = '0; req_row = '0; req_col = '0;
  endtask

  task automatic set_req(input int i, input logic [1:0] dir, input logic bul,
                         input logic brk, input logic [4:0] row, input logic [4:0] col);
    req[i]           = 1'b1;
    req_dir[2*i +: 2] = dir;
    req_bul[i]       = bul;
    req_brk[i]       = brk;
    req_row[5*i +: 5] = row;
    req_col[5*i +: 5] = col;
  endtask

  initial begin
    for (int a = 0; a < 256; a++) rom_mem[a] = (32'(a) * 32'h9E37_79B1) ^ 32'hA5C3_0F96;
    Reset = 1'b1;
    clear_req();
    tick();
    tick();
    neg();
    check("reset_gnt", 32'(gnt), 32'h0);
    check("reset_rom_addr", 32'(rom_addr), 32'd0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_id", 32'(rsp_id), 32'd0);
    check("reset_rsp_pixel", 32'(rsp_pixel), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    tick();
    Reset = 1'b0;

    // Single request: requester 2, dir RIGHT, row 5, col 3.
    set_req(2, 2'd1, 1'b0, 1'b0, 5'd5, 5'd3);
    neg();
    check("single_gnt", 32'(gnt), 32'b0100);
    tick();
    clear_req();
    neg();
    check("single_rom_addr", 32'(rom_addr), 32'd37);
    check("single_busy", 32'(busy), 32'd1);
    check("single_no_early_rsp", 32'(rsp_valid), 32'd0);
    tick();
    neg();
    check("single_rsp_valid", 32'(rsp_valid), 32'd1);
    check("single_rsp_id", 32'(rsp_id), 32'd2);
    check("single_rsp_pixel", 32'(rsp_pixel), 32'(rom_mem[37][28]));
    tick();

    // Sprite select priority: bullet over brick, then brick alone.
    set_req(0, 2'd2, 1'b1, 1'b1, 5'd7, 5'd0);
    neg();
    check("prio_gnt_a", 32'(gnt), 32'b0001);
    tick();
    clear_req();
    neg();
    check("prio_bul_addr", 32'(rom_addr), 32'd135);
    tick();
    set_req(0, 2'd2, 1'b0, 1'b1, 5'd7, 5'd31);
    neg();
    check("prio_gnt_b", 32'(gnt), 32'b0001);
    tick();
    clear_req();
    neg();
    check("prio_brk_addr", 32'(rom_addr), 32'd167);
    tick();

    // Fairness from ptr=0 with all four requesting for 8 cycles.
    Reset = 1'b1;
    neg();
    tick();
    Reset = 1'b0;
    for (int i = 0; i < NREQ; i++)
      set_req(i, 2'(i), 1'b0, 1'b0, 5'(3*i + 1), 5'(7*i + 2));
    for (int i = 0; i < 10; i++) begin
      neg();
      if (i < 8) check("fair_gnt", 32'(gnt), 32'(1) << (i % 4));
      if (i >= 2) begin
        check("fair_rsp_valid", 32'(rsp_valid), 32'd1);
        check("fair_rsp_id", 32'(rsp_id), 32'((i - 2) % 4));
      end
      tick();
      if (i == 7) clear_req();
    end

    // Skip and withdraw: ptr=0 -> grant 0 -> ptr=1, then req=1001.
    set_req(0, 2'd0, 1'b0, 1'b0, 5'd2, 5'd4);
    neg();
    check("skip_gnt_0", 32'(gnt), 32'b0001);
    tick();
    set_req(3, 2'd3, 1'b0, 1'b0, 5'd9, 5'd10);
    neg();
    check("skip_gnt_3", 32'(gnt), 32'b1000);
    tick();
    req[3] = 1'b0;
    set_req(1, 2'd1, 1'b0, 1'b0, 5'd11, 5'd12);
    neg();
    check("skip_gnt_0b", 32'(gnt), 32'b0001);
    tick();
    clear_req();
    neg();
    check("withdraw_rsp_id_3", 32'(rsp_id), 32'd3);
    tick();
    neg();
    check("withdraw_rsp_valid", 32'(rsp_valid), 32'd1);
    check("withdraw_rsp_id_0", 32'(rsp_id), 32'd0);
    tick();
    neg();
    check("withdraw_no_id1", 32'(rsp_valid), 32'd0);
    tick();

    // Reset mid-flight: grant on N, Reset on N+1.
    set_req(1, 2'd2, 1'b0, 1'b0, 5'd4, 5'd5);
    neg();
    check("rst_gnt_n", 32'(gnt), 32'b0010);
    tick();
    clear_req();
    Reset = 1'b1;
    set_req(2, 2'd0, 1'b0, 1'b0, 5'd1, 5'd1);
    neg();
    check("rst_gnt_masked", 32'(gnt), 32'd0);
    check("rst_rsp_n1", 32'(rsp_valid), 32'd0);
    tick();
    Reset = 1'b0;
    clear_req();
    neg();
    check("rst_rsp_n2", 32'(rsp_valid), 32'd0);
    tick();
    neg();
    check("rst_rsp_n3", 32'(rsp_valid), 32'd0);
    check("rst_busy_n3", 32'(busy), 32'd0);
    tick();
    for (int i = 0; i < NREQ; i++) set_req(i, 2'd0, 1'b0, 1'b0, 5'd0, 5'd0);
    neg();
    check("rst_ptr_zero", 32'(gnt), 32'b0001);
    tick();
    clear_req();

    // Idle: drain, then 10 quiet cycles; ptr must remain 1.
    repeat (3) tick();
    for (int i = 0; i < 10; i++) begin
      neg();
      check("idle_gnt", 32'(gnt), 32'd0);
      check("idle_rsp_valid", 32'(rsp_valid), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
      tick();
    end
    for (int i = 0; i < NREQ; i++) set_req(i, 2'd3, 1'b0, 1'b0, 5'd6, 5'd6);
    neg();
    check("idle_ptr_held", 32'(gnt), 32'b0010);
    tick();
    clear_req();

    // Mixed request patterns, checked by the model every cycle.
    for (int c = 0; c < 60; c++) begin
      clear_req();
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(0, 1) == 1)
          set_req(i, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                  5'($urandom_range(0, 31)));
      end
      tick();
    end
    clear_req();
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
